// File: rtl/race_pkg.sv
// -----------------------------------------------------------------------------
// race_pkg
// Shared definitions for the typing-race controller: FSM state encodings,
// PS/2 scan-code constants (bit 8 = E0 extended prefix), value limits, the
// decoded key strobe bundle and the countdown digit helper.
// -----------------------------------------------------------------------------
package race_pkg;

    typedef enum logic [1:0] {
        ST_SELECT    = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_INGAME    = 2'd2,
        ST_FINISH    = 2'd3
    } race_state_t;

    // One-hot strobes for the keys the controller cares about.
    typedef struct packed {
        logic enter;
        logic esc;
        logic left;
        logic right;
        logic up;
        logic down;
    } key_strobe_t;

    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;

    localparam logic [6:0] VALUE_MIN = 7'd5;
    localparam logic [6:0] VALUE_MAX = 7'd95;
    localparam logic [6:0] VALUE_RST = 7'd15;

    // Seconds shown on the countdown display: ceil(remaining_ticks / 100),
    // valid for remaining in 0..900.
    function automatic logic [3:0] cd_digit_of(input logic [9:0] remaining);
        logic [3:0] digit;
        digit = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (remaining > 10'(100 * (i - 1))) begin
                digit = 4'(i);
            end else begin
                digit = digit;
            end
        end
        return digit;
    endfunction

endpackage

// File: rtl/race_if.sv
// -----------------------------------------------------------------------------
// race_if
// Bundle of all non-clock signals of race_controller.
//   master modport (environment): drives tick, key_valid, last_change,
//     key_pressed, finish, wpm_in, acc_in; observes the controller outputs.
//   slave modport (race_controller): the mirror image.
// Outputs: state, mode, value, cd_digit, res_wpm, res_acc and, when the
// macro RACE_BEST_SCORE_EN is defined, best_wpm and new_best.
// -----------------------------------------------------------------------------
interface race_if;
    import race_pkg::*;

    logic        tick;
    logic        key_valid;
    logic [8:0]  last_change;
    logic        key_pressed;
    logic        finish;
    logic [9:0]  wpm_in;
    logic [9:0]  acc_in;

    race_state_t state;
    logic        mode;
    logic [6:0]  value;
    logic [3:0]  cd_digit;
    logic [9:0]  res_wpm;
    logic [9:0]  res_acc;
`ifdef RACE_BEST_SCORE_EN
    logic [9:0]  best_wpm;
    logic        new_best;
`endif

    modport master (
`ifdef RACE_BEST_SCORE_EN
        input  best_wpm,
        input  new_best,
`endif
        output tick, key_valid, last_change, key_pressed, finish, wpm_in, acc_in,
        input  state, mode, value, cd_digit, res_wpm, res_acc
    );

    modport slave (
`ifdef RACE_BEST_SCORE_EN
        output best_wpm,
        output new_best,
`endif
        input  tick, key_valid, last_change, key_pressed, finish, wpm_in, acc_in,
        output state, mode, value, cd_digit, res_wpm, res_acc
    );

endinterface

// File: rtl/race_key_decode.sv
// -----------------------------------------------------------------------------
// race_key_decode
// Combinational scan-code decoder. A key event is a key_valid strobe while
// the key is held (make); breaks and codes outside the known set yield no
// strobe.
// Ports: key_valid, last_change[8:0], key_pressed -> keys (one-hot strobes).
// -----------------------------------------------------------------------------
module race_key_decode
    import race_pkg::*;
(
    input  logic        key_valid,
    input  logic [8:0]  last_change,
    input  logic        key_pressed,
    output key_strobe_t keys
);

    // Map the current make event to at most one key strobe.
    always_comb begin
        keys = '0;
        if (key_valid && key_pressed) begin
            case (last_change)
                KEY_ENTER: keys.enter = 1'b1;
                KEY_ESC:   keys.esc   = 1'b1;
                KEY_LEFT:  keys.left  = 1'b1;
                KEY_RIGHT: keys.right = 1'b1;
                KEY_UP:    keys.up    = 1'b1;
                KEY_DOWN:  keys.down  = 1'b1;
                default:   keys       = '0;
            endcase
        end else begin
            keys = '0;
        end
    end

endmodule

// File: rtl/race_controller.sv
// -----------------------------------------------------------------------------
// race_controller
// Menu / countdown / in-game / result FSM of the typing race.
// Ports: clk, rst (synchronous, active-high), bus (race_if.slave): tick,
//   key_valid, last_change, key_pressed, finish, wpm_in, acc_in in;
//   state, mode, value, cd_digit, res_wpm, res_acc out (all registered).
// Parameters: CD_SEC (countdown seconds, 1..9), VALUE_STEP (menu step).
// Optional: define RACE_BEST_SCORE_EN to add best_wpm / new_best tracking.
// -----------------------------------------------------------------------------
module race_controller
    import race_pkg::*;
#(
    parameter int CD_SEC     = 3,
    parameter int VALUE_STEP = 5
) (
    input  logic  clk,
    input  logic  rst,
    race_if.slave bus
);

    localparam logic [9:0] CD_LOAD = 10'(CD_SEC * 100);

    key_strobe_t keys_s;

    race_state_t state_r, state_s;
    logic        mode_r, mode_s;
    logic [6:0]  value_r, value_s;
    logic [9:0]  cnt_r, cnt_s;
    logic [3:0]  cd_digit_r, cd_digit_s;
    logic [9:0]  res_wpm_r, res_wpm_s;
    logic [9:0]  res_acc_r, res_acc_s;
`ifdef RACE_BEST_SCORE_EN
    logic [9:0]  best_wpm_r, best_wpm_s;
    logic        new_best_r, new_best_s;
`endif

    logic        final_tick_s;
    logic        capture_s;
    logic [7:0]  up_sum_s;

    race_key_decode u_key_decode (
        .key_valid   (bus.key_valid),
        .last_change (bus.last_change),
        .key_pressed (bus.key_pressed),
        .keys        (keys_s)
    );

    // The tick that takes the countdown counter to zero ends the countdown.
    assign final_tick_s = (state_r == ST_COUNTDOWN) && bus.tick && (cnt_r <= 10'd1);
    assign capture_s    = (state_r == ST_INGAME) && bus.finish;
    assign up_sum_s     = {1'b0, value_r} + 8'(VALUE_STEP);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_SELECT;
            mode_r     <= 1'b0;
            value_r    <= VALUE_RST;
            cnt_r      <= 10'd0;
            cd_digit_r <= 4'd0;
            res_wpm_r  <= 10'd0;
            res_acc_r  <= 10'd0;
`ifdef RACE_BEST_SCORE_EN
            best_wpm_r <= 10'd0;
            new_best_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            value_r    <= value_s;
            cnt_r      <= cnt_s;
            cd_digit_r <= cd_digit_s;
            res_wpm_r  <= res_wpm_s;
            res_acc_r  <= res_acc_s;
`ifdef RACE_BEST_SCORE_EN
            best_wpm_r <= best_wpm_s;
            new_best_r <= new_best_s;
`endif
        end
    end

    // Next-state logic; ESC beats the final tick, finish beats ESC.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SELECT: begin
                if (keys_s.enter) begin
                    state_s = ST_COUNTDOWN;
                end else begin
                    state_s = ST_SELECT;
                end
            end
            ST_COUNTDOWN: begin
                if (keys_s.esc) begin
                    state_s = ST_SELECT;
                end else if (final_tick_s) begin
                    state_s = ST_INGAME;
                end else begin
                    state_s = ST_COUNTDOWN;
                end
            end
            ST_INGAME: begin
                if (bus.finish) begin
                    state_s = ST_FINISH;
                end else if (keys_s.esc) begin
                    state_s = ST_SELECT;
                end else begin
                    state_s = ST_INGAME;
                end
            end
            ST_FINISH: begin
                if (keys_s.enter || keys_s.esc) begin
                    state_s = ST_SELECT;
                end else begin
                    state_s = ST_FINISH;
                end
            end
            default: state_s = ST_SELECT;
        endcase
    end

    // Next values of the registered outputs and the countdown counter.
    always_comb begin
        mode_s     = mode_r;
        value_s    = value_r;
        cnt_s      = 10'd0;
        cd_digit_s = 4'd0;
        res_wpm_s  = res_wpm_r;
        res_acc_s  = res_acc_r;

        if (state_r == ST_SELECT) begin
            if (keys_s.left || keys_s.right) begin
                mode_s = ~mode_r;
            end else begin
                mode_s = mode_r;
            end
            if (keys_s.up) begin
                value_s = (up_sum_s > {1'b0, VALUE_MAX}) ? VALUE_MAX : up_sum_s[6:0];
            end else if (keys_s.down) begin
                value_s = ({1'b0, value_r} < ({1'b0, VALUE_MIN} + 8'(VALUE_STEP)))
                          ? VALUE_MIN : (value_r - 7'(VALUE_STEP));
            end else begin
                value_s = value_r;
            end
        end else begin
            mode_s  = mode_r;
            value_s = value_r;
        end

        // Counter is loaded on entry, counts ticks while staying, else idles at 0;
        // the digit is derived from the next count so it lines up with state.
        if (state_s == ST_COUNTDOWN) begin
            if (state_r != ST_COUNTDOWN) begin
                cnt_s = CD_LOAD;
            end else if (bus.tick) begin
                cnt_s = cnt_r - 10'd1;
            end else begin
                cnt_s = cnt_r;
            end
            cd_digit_s = cd_digit_of(cnt_s);
        end else begin
            cnt_s      = 10'd0;
            cd_digit_s = 4'd0;
        end

        if (capture_s) begin
            res_wpm_s = bus.wpm_in;
            res_acc_s = bus.acc_in;
        end else begin
            res_wpm_s = res_wpm_r;
            res_acc_s = res_acc_r;
        end
    end

`ifdef RACE_BEST_SCORE_EN
    // Best-score tracking: raise new_best on a record capture, drop it on leaving FINISH.
    always_comb begin
        best_wpm_s = best_wpm_r;
        new_best_s = new_best_r;
        if (capture_s) begin
            if (bus.wpm_in > best_wpm_r) begin
                best_wpm_s = bus.wpm_in;
                new_best_s = 1'b1;
            end else begin
                new_best_s = 1'b0;
            end
        end else if ((state_r == ST_FINISH) && (state_s != ST_FINISH)) begin
            new_best_s = 1'b0;
        end else begin
            new_best_s = new_best_r;
        end
    end

    assign bus.best_wpm = best_wpm_r;
    assign bus.new_best = new_best_r;
`endif

    assign bus.state    = state_r;
    assign bus.mode     = mode_r;
    assign bus.value    = value_r;
    assign bus.cd_digit = cd_digit_r;
    assign bus.res_wpm  = res_wpm_r;
    assign bus.res_acc  = res_acc_r;

endmodule

// File: tb/tb_race_controller.sv
// -----------------------------------------------------------------------------
// tb_race_controller
// Directed self-checking bench for race_controller: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences (countdown timing,
// saturation, same-cycle priorities, reset priority, optional best score).
// -----------------------------------------------------------------------------
module tb_race_controller;
    import race_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    race_if bus ();

    race_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic       kv;
        logic [8:0] code;
        logic       pr;
        logic       fin;
        logic [1:0] st;
        logic       m;
        logic [6:0] v;
        logic [3:0] cd;
        logic [9:0] rw;
        logic [9:0] ra;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [1:0] st, input logic m,
                         input logic [6:0] v, input logic [3:0] cd,
                         input logic [9:0] rw, input logic [9:0] ra);
        checks++;
        if (bus.state !== st || bus.mode !== m || bus.value !== v ||
            bus.cd_digit !== cd || bus.res_wpm !== rw || bus.res_acc !== ra) begin
            failures++;
            $display("FAIL %s: got state=%0d mode=%0d value=%0d cd=%0d res=%0d/%0d, expected state=%0d mode=%0d value=%0d cd=%0d res=%0d/%0d",
                     name, bus.state, bus.mode, bus.value, bus.cd_digit, bus.res_wpm, bus.res_acc,
                     st, m, v, cd, rw, ra);
        end
    endtask

`ifdef RACE_BEST_SCORE_EN
    task automatic check_best(input string name, input logic [9:0] best, input logic nb);
        checks++;
        if (bus.best_wpm !== best || bus.new_best !== nb) begin
            failures++;
            $display("FAIL %s: got best_wpm=%0d new_best=%0d, expected best_wpm=%0d new_best=%0d",
                     name, bus.best_wpm, bus.new_best, best, nb);
        end
    endtask
`endif

    // One clock with the given inputs; strobes drop again just after the edge.
    task automatic cyc(input logic tk, input logic kv, input logic [8:0] code,
                       input logic pr, input logic fin);
        bus.tick        = tk;
        bus.key_valid   = kv;
        bus.last_change = code;
        bus.key_pressed = pr;
        bus.finish      = fin;
        @(posedge clk);
        #1;
        bus.tick        = 1'b0;
        bus.key_valid   = 1'b0;
        bus.key_pressed = 1'b0;
        bus.finish      = 1'b0;
    endtask

    task automatic key(input logic [8:0] code);
        cyc(1'b0, 1'b1, code, 1'b1, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic run_race(input logic [9:0] wpm, input logic [9:0] acc);
        key(KEY_ENTER);
        ticks(300);
        bus.wpm_in = wpm;
        bus.acc_in = acc;
        cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst             = 1'b1;
        bus.tick        = 1'b0;
        bus.key_valid   = 1'b0;
        bus.last_change = 9'h000;
        bus.key_pressed = 1'b0;
        bus.finish      = 1'b0;
        bus.wpm_in      = 10'd0;
        bus.acc_in      = 10'd0;

        //              tk    kv    code       pr    fin   st    m     v      cd    rw      ra
        vecs[0]  = '{1'b0, 1'b1, KEY_UP,    1'b1, 1'b0, 2'd0, 1'b0, 7'd20, 4'd0, 10'd0, 10'd0};
        vecs[1]  = '{1'b0, 1'b1, KEY_DOWN,  1'b1, 1'b0, 2'd0, 1'b0, 7'd15, 4'd0, 10'd0, 10'd0};
        vecs[2]  = '{1'b0, 1'b1, KEY_DOWN,  1'b1, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[3]  = '{1'b0, 1'b1, KEY_RIGHT, 1'b1, 1'b0, 2'd0, 1'b1, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[4]  = '{1'b0, 1'b1, KEY_LEFT,  1'b1, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[5]  = '{1'b0, 1'b1, KEY_ENTER, 1'b0, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[6]  = '{1'b0, 1'b0, KEY_ENTER, 1'b1, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[7]  = '{1'b0, 1'b1, 9'h075,    1'b1, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[8]  = '{1'b0, 1'b1, 9'h06B,    1'b1, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[9]  = '{1'b0, 1'b1, KEY_ENTER, 1'b1, 1'b0, 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0};
        vecs[10] = '{1'b0, 1'b1, KEY_UP,    1'b1, 1'b0, 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0};
        vecs[11] = '{1'b0, 1'b1, KEY_RIGHT, 1'b1, 1'b0, 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0};
        vecs[12] = '{1'b1, 1'b0, 9'h000,    1'b0, 1'b0, 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0};
        vecs[13] = '{1'b0, 1'b1, KEY_ESC,   1'b1, 1'b0, 2'd0, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0};
        vecs[14] = '{1'b0, 1'b1, KEY_ENTER, 1'b1, 1'b0, 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0};
        vecs[15] = '{1'b0, 1'b0, 9'h000,    1'b0, 1'b1, 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0};

        // Reset, with an ENTER event present that reset must override.
        idle(1);
        key(KEY_ENTER);
        check("reset", 2'd0, 1'b0, 7'd15, 4'd0, 10'd0, 10'd0);
        rst = 1'b0;

        bus.wpm_in = 10'd11;
        bus.acc_in = 10'd12;
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].tk, vecs[i].kv, vecs[i].code, vecs[i].pr, vecs[i].fin);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].m, vecs[i].v,
                  vecs[i].cd, vecs[i].rw, vecs[i].ra);
        end

        // Countdown timing from a fresh 300-tick load.
        ticks(99);
        check("cd_99", 2'd1, 1'b0, 7'd10, 4'd3, 10'd0, 10'd0);
        ticks(1);
        check("cd_100", 2'd1, 1'b0, 7'd10, 4'd2, 10'd0, 10'd0);
        ticks(50);
        idle(5);
        check("cd_hold", 2'd1, 1'b0, 7'd10, 4'd2, 10'd0, 10'd0);
        ticks(50);
        check("cd_200", 2'd1, 1'b0, 7'd10, 4'd1, 10'd0, 10'd0);
        ticks(99);
        check("cd_299", 2'd1, 1'b0, 7'd10, 4'd1, 10'd0, 10'd0);
        ticks(1);
        check("cd_300", 2'd2, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0);

        // In game: menu keys ignored; finish beats ESC and captures results.
        key(KEY_UP);
        check("ingame_up", 2'd2, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0);
        key(KEY_ENTER);
        check("ingame_enter", 2'd2, 1'b0, 7'd10, 4'd0, 10'd0, 10'd0);
        bus.wpm_in = 10'd42;
        bus.acc_in = 10'd97;
        cyc(1'b0, 1'b1, KEY_ESC, 1'b1, 1'b1);
        check("finish_esc", 2'd3, 1'b0, 7'd10, 4'd0, 10'd42, 10'd97);
        bus.wpm_in = 10'd5;
        cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("finish_hold", 2'd3, 1'b0, 7'd10, 4'd0, 10'd42, 10'd97);
        key(KEY_ESC);
        check("finish_to_sel", 2'd0, 1'b0, 7'd10, 4'd0, 10'd42, 10'd97);

        // Value saturation and mode toggling.
        for (int i = 0; i < 17; i++) key(KEY_UP);
        check("up_17", 2'd0, 1'b0, 7'd95, 4'd0, 10'd42, 10'd97);
        for (int i = 0; i < 3; i++) key(KEY_UP);
        check("up_sat", 2'd0, 1'b0, 7'd95, 4'd0, 10'd42, 10'd97);
        for (int i = 0; i < 20; i++) key(KEY_DOWN);
        check("down_sat", 2'd0, 1'b0, 7'd5, 4'd0, 10'd42, 10'd97);
        key(KEY_RIGHT);
        check("right1", 2'd0, 1'b1, 7'd5, 4'd0, 10'd42, 10'd97);
        key(KEY_RIGHT);
        check("right2", 2'd0, 1'b0, 7'd5, 4'd0, 10'd42, 10'd97);
        key(KEY_RIGHT);

        // ESC on the final countdown tick wins; results untouched.
        key(KEY_ENTER);
        ticks(299);
        check("cd2_299", 2'd1, 1'b1, 7'd5, 4'd1, 10'd42, 10'd97);
        cyc(1'b1, 1'b1, KEY_ESC, 1'b1, 1'b0);
        check("esc_final_tick", 2'd0, 1'b1, 7'd5, 4'd0, 10'd42, 10'd97);
        key(KEY_ENTER);
        check("cd_reload", 2'd1, 1'b1, 7'd5, 4'd3, 10'd42, 10'd97);
        ticks(300);
        bus.wpm_in = 10'd30;
        bus.acc_in = 10'd88;
        cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        check("finish2", 2'd3, 1'b1, 7'd5, 4'd0, 10'd30, 10'd88);
        key(KEY_UP);
        check("finish_up", 2'd3, 1'b1, 7'd5, 4'd0, 10'd30, 10'd88);
        key(KEY_ENTER);
        check("finish_enter", 2'd0, 1'b1, 7'd5, 4'd0, 10'd30, 10'd88);

        // Reset priority mid-countdown and mid-game.
        key(KEY_ENTER);
        ticks(10);
        rst = 1'b1;
        key(KEY_ESC);
        rst = 1'b0;
        check("rst_cd", 2'd0, 1'b0, 7'd15, 4'd0, 10'd0, 10'd0);
        key(KEY_ENTER);
        ticks(300);
        check("ingame3", 2'd2, 1'b0, 7'd15, 4'd0, 10'd0, 10'd0);
        rst = 1'b1;
        bus.wpm_in = 10'd77;
        cyc(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        rst = 1'b0;
        check("rst_ingame", 2'd0, 1'b0, 7'd15, 4'd0, 10'd0, 10'd0);

`ifdef RACE_BEST_SCORE_EN
        check_best("best_rst", 10'd0, 1'b0);
        run_race(10'd30, 10'd60);
        check_best("best_30", 10'd30, 1'b1);
        key(KEY_ENTER);
        check_best("best_clr1", 10'd30, 1'b0);
        run_race(10'd20, 10'd60);
        check_best("best_20", 10'd30, 1'b0);
        key(KEY_ENTER);
        run_race(10'd50, 10'd60);
        check_best("best_50", 10'd50, 1'b1);
        key(KEY_ENTER);
        check_best("best_clr3", 10'd50, 1'b0);
`else
        run_race(10'd50, 10'd60);
        check("race_plain", 2'd3, 1'b0, 7'd15, 4'd0, 10'd50, 10'd60);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
